// File: rtl/mac_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_job_scheduler_if
// Description : Bundles the requester, MAC and response signals of the
//               mac_job_scheduler into one interface.
//               slave  - scheduler view (consumes requests, drives the MAC,
//                        produces responses)
//               master - environment view (requesters, MAC, result consumer)
// Ports       : req_valid/req_ready/req_a/req_b/req_c  requester side
//               mac_valid/mac_a/mac_b/mac_c/mac_ready/mac_out  MAC side
//               rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err  response side
//               busy  scheduler not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 6,
    parameter int SETS    = 16,
    parameter int OUT_W   = 2*SIZE+SETS
);
    localparam int c_lane_w = SETS*SIZE;
    localparam int c_id_w   = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*c_lane_w-1:0] req_a;
    logic [NUM_REQ*c_lane_w-1:0] req_b;
    logic [NUM_REQ*c_lane_w-1:0] req_c;

    logic                        mac_valid;
    logic [c_lane_w-1:0]         mac_a;
    logic [c_lane_w-1:0]         mac_b;
    logic [c_lane_w-1:0]         mac_c;
    logic                        mac_ready;
    logic [OUT_W-1:0]            mac_out;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [c_id_w-1:0]           rsp_id;
    logic [OUT_W-1:0]            rsp_data;
    logic                        rsp_err;
    logic                        busy;

    modport slave (
        input  req_valid, req_a, req_b, req_c, mac_ready, mac_out, rsp_ready,
        output req_ready, mac_valid, mac_a, mac_b, mac_c,
               rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_c, mac_ready, mac_out, rsp_ready,
        input  req_ready, mac_valid, mac_a, mac_b, mac_c,
               rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mac_job_scheduler
// Description : Shares one MAC between NUM_REQ requesters. Jobs are granted
//               round-robin, launched with a one-cycle mac_valid pulse, and
//               the captured mac_out is returned tagged with the requester
//               id. A watchdog aborts a job whose mac_ready never arrives.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous, active-high
//               bus    - mac_job_scheduler_if.slave (requests, MAC, response)
// Revision    : 1.0 - initial release
// ============================================================================
module mac_job_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int SIZE     = 6,
    parameter int SETS     = 16,
    parameter int OUT_W    = 2*SIZE+SETS,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = (1 << (SIZE+1)) + 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    mac_job_scheduler_if.slave  bus
);
    localparam int c_lane_w = SETS*SIZE;
    localparam int c_id_w   = $clog2(NUM_REQ);
    localparam int c_scan_w = c_id_w + 1;
    localparam int c_cnt_w  = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_id_w-1:0]     r_rr_ptr;
    logic [c_cnt_w-1:0]    r_wait_cnt;

    logic [NUM_REQ-1:0]    r_req_ready;
    logic                  r_mac_valid;
    logic [c_lane_w-1:0]   r_mac_a;
    logic [c_lane_w-1:0]   r_mac_b;
    logic [c_lane_w-1:0]   r_mac_c;
    logic                  r_rsp_valid;
    logic [c_id_w-1:0]     r_rsp_id;
    logic [OUT_W-1:0]      r_rsp_data;
    logic                  r_rsp_err;

    logic [c_lane_w-1:0]   w_req_a [NUM_REQ];
    logic [c_lane_w-1:0]   w_req_b [NUM_REQ];
    logic [c_lane_w-1:0]   w_req_c [NUM_REQ];

    logic                  w_grant_any;
    logic [c_id_w-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0]    w_grant_onehot;
    logic [c_id_w-1:0]     w_rr_next;
    logic [c_scan_w-1:0]   w_scan;

    // Split the flat operand buses into one entry per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_a[gi] = bus.req_a[gi*c_lane_w +: c_lane_w];
        assign w_req_b[gi] = bus.req_b[gi*c_lane_w +: c_lane_w];
        assign w_req_c[gi] = bus.req_c[gi*c_lane_w +: c_lane_w];
    end

    // Round-robin scan: first requesting index at or after r_rr_ptr. The
    // scan index is one bit wider so rr_ptr+k never overflows before the
    // modulo wrap.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + c_scan_w'(k);
            if (w_scan >= c_scan_w'(NUM_REQ)) begin
                w_scan = w_scan - c_scan_w'(NUM_REQ);
            end
            if (!w_grant_any && bus.req_valid[w_scan[c_id_w-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan[c_id_w-1:0];
            end
        end
    end

    always_comb begin
        w_grant_onehot              = '0;
        w_grant_onehot[w_grant_idx] = 1'b1;
    end

    assign w_rr_next = (w_grant_idx == c_id_w'(NUM_REQ-1)) ? '0
                                                           : w_grant_idx + c_id_w'(1);

    // All outputs are registered, so each one appears the cycle after the
    // state that decides it: req_ready is high in ISSUE and mac_valid in the
    // first WAIT cycle (wait_cnt=0), keeping grant -> launch at one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_wait_cnt  <= '0;
            r_req_ready <= '0;
            r_mac_valid <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_c     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_mac_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_req_ready <= w_grant_onehot;
                        r_mac_a     <= w_req_a[w_grant_idx];
                        r_mac_b     <= w_req_b[w_grant_idx];
                        r_mac_c     <= w_req_c[w_grant_idx];
                        r_rsp_id    <= w_grant_idx;
                        r_rr_ptr    <= w_rr_next;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mac_valid <= 1'b1;
                    r_wait_cnt  <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // A qualified mac_ready takes priority over the watchdog.
                    if (bus.mac_ready && (r_wait_cnt >= c_cnt_w'(MIN_WAIT))) begin
                        r_rsp_data  <= bus.mac_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wait_cnt == c_cnt_w'(TIMEOUT-1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt  <= r_wait_cnt + c_cnt_w'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.mac_valid = r_mac_valid;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.mac_c     = r_mac_c;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_job_scheduler
// Description : Scoreboard bench for mac_job_scheduler. Stimulus pushes the
//               expected response of every job; a monitor pops and compares
//               on each accepted response and checks grant/launch timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_job_scheduler;
    localparam int NUM_REQ  = 4;
    localparam int SIZE     = 6;
    localparam int SETS     = 16;
    localparam int OUT_W    = 28;
    localparam int MIN_WAIT = 2;
    localparam int TIMEOUT  = 136;
    localparam int LANE_W   = SETS*SIZE;

    typedef struct {
        logic [1:0]       id;
        logic [OUT_W-1:0] data;
        logic             err;
    } rsp_t;

    rsp_t  exp_q[$];
    int    grant_log[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    mac_valid_cnt = 0;

    logic [LANE_W-1:0] op_a [NUM_REQ];
    logic [LANE_W-1:0] op_b [NUM_REQ];
    logic [LANE_W-1:0] op_c [NUM_REQ];

    // MAC model controls: mac_delay = -1 means the MAC never completes.
    int               mac_delay     = 5;
    bit               mac_early     = 1'b0;
    bit               mac_use_fixed = 1'b1;
    logic [OUT_W-1:0] mac_fixed     = '0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_job_scheduler_if #(.NUM_REQ(NUM_REQ), .SIZE(SIZE), .SETS(SETS), .OUT_W(OUT_W)) bus ();

    mac_job_scheduler #(
        .NUM_REQ (NUM_REQ),
        .SIZE    (SIZE),
        .SETS    (SETS),
        .OUT_W   (OUT_W),
        .MIN_WAIT(MIN_WAIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [OUT_W-1:0] d, input bit err);
        rsp_t e;
        e.id   = 2'(id);
        e.data = d;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    function automatic logic [OUT_W-1:0] derived_data(input int i);
        return op_a[i][OUT_W-1:0] ^ op_b[i][OUT_W-1:0] ^ op_c[i][OUT_W-1:0];
    endfunction

    task automatic check_reset_outputs(input string p);
        check({p, "_ctrl"}, 128'({bus.req_ready, bus.mac_valid, bus.rsp_valid, bus.rsp_err, bus.busy}), 128'(0));
        check({p, "_mac_ops"}, 128'(bus.mac_a | bus.mac_b | bus.mac_c), 128'(0));
        check({p, "_rsp_id"}, 128'(bus.rsp_id), 128'(0));
        check({p, "_rsp_data"}, 128'(bus.rsp_data), 128'(0));
    endtask

    // Single-requester job: checks grant vector, launch one cycle later and
    // the mac_valid -> rsp_valid distance in cycles.
    task automatic run_job(input logic [NUM_REQ-1:0] mask, input int exp_lat, input string name);
        bit seen;
        int lat;
        bus.req_valid = mask;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) seen = 1'b1;
        end
        check({name, "_grant"}, 128'(bus.req_ready), 128'(mask));
        bus.req_valid = '0;
        if (!seen) return;
        @(negedge clk);
        check({name, "_mac_valid"}, 128'(bus.mac_valid), 128'(1));
        lat  = 0;
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check({name, "_latency"}, 128'(lat), 128'(exp_lat));
        @(negedge clk);
    endtask

    // MAC model: k tracks wait_cnt (0 in the mac_valid cycle).
    initial begin : mac_model
        int k;
        bit active;
        k = 0;
        active = 1'b0;
        bus.mac_ready = 1'b0;
        bus.mac_out   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
                k = 0;
            end else if (bus.mac_valid) begin
                active = 1'b1;
                k = 0;
            end else if (active) begin
                k++;
            end
            bus.mac_ready = 1'b0;
            bus.mac_out   = 28'h5A5A5A5 ^ 28'(k);
            if (active) begin
                if (k == mac_delay) begin
                    bus.mac_ready = 1'b1;
                    bus.mac_out   = mac_use_fixed ? mac_fixed
                                  : (bus.mac_a[OUT_W-1:0] ^ bus.mac_b[OUT_W-1:0] ^ bus.mac_c[OUT_W-1:0]);
                    active = 1'b0;
                end else if (mac_early && k <= 1) begin
                    bus.mac_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: samples just after the falling edge so inputs driven on that
    // edge are already visible.
    initial begin : monitor
        bit   pg_v;
        int   pg;
        bit   prev_mv;
        rsp_t e;
        pg_v = 1'b0;
        pg = 0;
        prev_mv = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                pg_v = 1'b0;
                prev_mv = 1'b0;
            end else begin
                if (pg_v) begin
                    check("launch_after_grant", 128'(bus.mac_valid), 128'(1));
                    check("mac_a_route", 128'(bus.mac_a), 128'(op_a[pg]));
                    check("mac_b_route", 128'(bus.mac_b), 128'(op_b[pg]));
                    check("mac_c_route", 128'(bus.mac_c), 128'(op_c[pg]));
                end
                if (bus.mac_valid) begin
                    mac_valid_cnt++;
                    check("mac_valid_single", 128'(prev_mv), 128'(0));
                end
                prev_mv = bus.mac_valid;
                pg_v = 1'b0;
                if (bus.req_ready != '0) begin
                    check("grant_onehot", 128'($onehot(bus.req_ready)), 128'(1));
                    for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) pg = i;
                    pg_v = 1'b1;
                    grant_log.push_back(pg);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: got id=%0d data=0x%0h err=%0d, required no response",
                                 bus.rsp_id, bus.rsp_data, bus.rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", 128'(bus.rsp_id), 128'(e.id));
                        check("rsp_data", 128'(bus.rsp_data), 128'(e.data));
                        check("rsp_err", 128'(bus.rsp_err), 128'(e.err));
                    end
                end
            end
        end
    end

    initial begin : stim
        int cnt;
        int bad;
        int grants;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        for (int i = 0; i < NUM_REQ; i++) begin
            for (int l = 0; l < SETS; l++) begin
                op_a[i][l*SIZE +: SIZE] = 6'((i*16 + l) % 64);
                op_b[i][l*SIZE +: SIZE] = 6'(63 - ((i*16 + l) % 64));
                op_c[i][l*SIZE +: SIZE] = 6'((i*5 + l*3) % 64);
            end
            bus.req_a[i*LANE_W +: LANE_W] = op_a[i];
            bus.req_b[i*LANE_W +: LANE_W] = op_b[i];
            bus.req_c[i*LANE_W +: LANE_W] = op_c[i];
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single job from requester 2, MAC answers 70 cycles after launch
        mac_delay = 70; mac_early = 1'b0; mac_use_fixed = 1'b1; mac_fixed = 28'd12345;
        push_exp(2, 28'd12345, 1'b0);
        run_job(4'b0100, 71, "single");

        // Early strobes at wait_cnt 0 and 1 are ignored; real one at 20
        mac_delay = 20; mac_early = 1'b1; mac_fixed = 28'hABCDE;
        push_exp(1, 28'hABCDE, 1'b0);
        run_job(4'b0010, 21, "early");
        mac_early = 1'b0;

        // Watchdog: response TIMEOUT cycles after entering WAIT, then recovery
        mac_delay = -1;
        push_exp(3, '0, 1'b1);
        run_job(4'b1000, 136, "timeout");
        mac_delay = 3; mac_fixed = 28'hFEDCBA;
        push_exp(0, 28'hFEDCBA, 1'b0);
        run_job(4'b0001, 4, "after_timeout");

        // Round-robin with all requesters valid, starting from rr_ptr=0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        grant_log.delete();
        mac_valid_cnt = 0;
        mac_delay = 5; mac_use_fixed = 1'b0;
        for (int j = 0; j < 5; j++) push_exp(order[j], derived_data(order[j]), 1'b0);
        bus.req_valid = 4'b1111;
        cnt = 0;
        for (int n = 0; n < 600 && cnt < 5; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt++;
        end
        bus.req_valid = '0;
        check("rr_responses", 128'(cnt), 128'(5));
        repeat (5) @(negedge clk);
        check("rr_grant_count", 128'(grant_log.size()), 128'(5));
        for (int j = 0; j < 5; j++) begin
            if (j < grant_log.size()) check("rr_grant_order", 128'(grant_log[j]), 128'(order[j]));
        end
        check("rr_mac_valid_count", 128'(mac_valid_cnt), 128'(5));

        // Backpressure: response held 50 cycles, no new grant meanwhile
        mac_use_fixed = 1'b1; mac_fixed = 28'h7654321; mac_delay = 10;
        bus.rsp_ready = 1'b0;
        push_exp(2, 28'h7654321, 1'b0);
        bus.req_valid = 4'b0100;
        cnt = 0;
        for (int n = 0; n < 20 && cnt == 0; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) cnt = 1;
        end
        check("bp_grant", 128'(bus.req_ready), 128'(4'b0100));
        bus.req_valid = 4'b1111;
        cnt = 0;
        for (int n = 0; n < 50 && cnt == 0; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt = 1;
        end
        check("bp_rsp_seen", 128'(cnt), 128'(1));
        bad = 0;
        grants = 0;
        for (int n = 0; n < 50; n++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 ||
                bus.rsp_data !== 28'h7654321 || bus.rsp_err !== 1'b0 || bus.busy !== 1'b1) bad++;
            if (bus.req_ready != '0) grants++;
            @(negedge clk);
        end
        check("bp_stable", 128'(bad), 128'(0));
        check("bp_no_grant", 128'(grants), 128'(0));
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_released", 128'({bus.rsp_valid, bus.busy}), 128'(0));

        // Reset in mid-WAIT: everything returns to reset values, no response
        mac_delay = -1;
        bus.req_valid = 4'b0010;
        cnt = 0;
        for (int n = 0; n < 20 && cnt == 0; n++) begin
            @(negedge clk);
            if (bus.req_ready != '0) cnt = 1;
        end
        bus.req_valid = '0;
        check("midrst_grant", 128'(bus.req_ready), 128'(4'b0010));
        repeat (10) @(negedge clk);
        check("midrst_in_wait", 128'(bus.busy), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst_idle", 128'({bus.rsp_valid, bus.busy}), 128'(0));
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "bench time limit exceeded");
    end
endmodule
`default_nettype wire
